// File: rtl/press_classifier_pkg.sv
// rtl/press_classifier_pkg.sv - state encoding, default counts and timer sizing for press_classifier
// Contents:
//   state_t          classifier FSM states
//   DEF_*_CNT        default cycle counts at 50 MHz
//   timer_width()    bits needed for a counter covering the largest count
package press_classifier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESSED  = 3'd1,
        ST_WAIT2    = 3'd2,
        ST_PRESSED2 = 3'd3,
        ST_HELD     = 3'd4
    } state_t;

    localparam int DEF_LONG_CNT   = 50_000_000;
    localparam int DEF_DCLK_CNT   = 15_000_000;
    localparam int DEF_REPEAT_CNT = 10_000_000;

    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/press_timer.sv
// rtl/press_timer.sv - clearable, enabled, saturating up-counter with terminal compare
// Ports:
//   i_clk     clock
//   i_resetn  synchronous active-low reset
//   i_clear   zero the count this edge (wins over enable)
//   i_en      count enable
//   i_term    terminal value to compare against
//   o_term    high while the count equals i_term
module press_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    input  logic         i_clear,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_term
);

    logic [W-1:0] r_count;

    // Holds at all-ones instead of wrapping so a stale timer never re-fires.
    always_ff @(posedge i_clk) begin
        if (!i_resetn || i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_term = (r_count == i_term);

endmodule

// File: rtl/press_classifier.sv
// rtl/press_classifier.sv - classifies a debounced button into single, double, long press and auto-repeat
// Optional feature: define PRESS_CLASSIFIER_REPEAT_EN to enable the auto-repeat tick in HELD.
// Ports:
//   clk_50MHz_i    system clock
//   rst_sync_la_i  synchronous active-low reset
//   one_shot_i     single-cycle press pulse from the debouncer
//   sw_clean_i     debounced switch level, 1 = pressed
//   single_o       one-cycle pulse: single click
//   double_o       one-cycle pulse: double click
//   long_o         one-cycle pulse: long press
//   repeat_o       one-cycle pulse: auto-repeat tick (0 when the feature is off)
//   busy_o         high whenever the classifier is not idle
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int LONG_CNT   = DEF_LONG_CNT,
    parameter int DCLK_CNT   = DEF_DCLK_CNT,
    parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
    input  logic clk_50MHz_i,
    input  logic rst_sync_la_i,
    input  logic one_shot_i,
    input  logic sw_clean_i,
    output logic single_o,
    output logic double_o,
    output logic long_o,
    output logic repeat_o,
    output logic busy_o
);

    localparam int TW = timer_width(LONG_CNT, DCLK_CNT, REPEAT_CNT);

    state_t        r_state;
    state_t        w_next;
    logic          w_single;
    logic          w_double;
    logic          w_long;
    logic          w_tmr_clear;
    logic          w_tmr_term;
    logic [TW-1:0] w_tmr_cmp;
    logic          r_single;
    logic          r_double;
    logic          r_long;
    logic          r_busy;

    // One shared timer: only PRESSED and WAIT2 look at it, each with its own limit.
    assign w_tmr_cmp   = (r_state == ST_PRESSED) ? TW'(LONG_CNT - 1) : TW'(DCLK_CNT - 1);
    assign w_tmr_clear = (w_next != r_state);

    press_timer #(.W(TW)) u_main_timer (
        .i_clk    (clk_50MHz_i),
        .i_resetn (rst_sync_la_i),
        .i_clear  (w_tmr_clear),
        .i_en     (1'b1),
        .i_term   (w_tmr_cmp),
        .o_term   (w_tmr_term)
    );

    // Release beats long timeout; second press beats double-click timeout.
    always_comb begin
        w_next   = r_state;
        w_single = 1'b0;
        w_double = 1'b0;
        w_long   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (one_shot_i) w_next = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (!sw_clean_i) begin
                    w_next = ST_WAIT2;
                end else if (w_tmr_term) begin
                    w_next = ST_HELD;
                    w_long = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (one_shot_i) begin
                    w_next   = ST_PRESSED2;
                    w_double = 1'b1;
                end else if (w_tmr_term) begin
                    w_next   = ST_IDLE;
                    w_single = 1'b1;
                end
            end
            ST_PRESSED2, ST_HELD: begin
                if (!sw_clean_i) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz_i) begin
        if (!rst_sync_la_i) begin
            r_state  <= ST_IDLE;
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_single <= w_single;
            r_double <= w_double;
            r_long   <= w_long;
            r_busy   <= (w_next != ST_IDLE);
        end
    end

    assign single_o = r_single;
    assign double_o = r_double;
    assign long_o   = r_long;
    assign busy_o   = r_busy;

`ifdef PRESS_CLASSIFIER_REPEAT_EN
    logic          w_rep_term;
    logic          w_rep_clear;
    logic          w_repeat;
    logic [TW-1:0] w_rep_cmp;
    logic          r_repeat;

    // Held at zero outside HELD, so the period is counted from HELD entry;
    // self-clears on each tick to restart the period.
    assign w_rep_cmp   = TW'(REPEAT_CNT - 1);
    assign w_rep_clear = (r_state != ST_HELD) || w_rep_term;
    assign w_repeat    = (r_state == ST_HELD) && sw_clean_i && w_rep_term;

    press_timer #(.W(TW)) u_repeat_timer (
        .i_clk    (clk_50MHz_i),
        .i_resetn (rst_sync_la_i),
        .i_clear  (w_rep_clear),
        .i_en     (1'b1),
        .i_term   (w_rep_cmp),
        .o_term   (w_rep_term)
    );

    always_ff @(posedge clk_50MHz_i) begin
        if (!rst_sync_la_i) begin
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= w_repeat;
        end
    end

    assign repeat_o = r_repeat;
`else
    assign repeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_press_classifier.sv
// tb/tb_press_classifier.sv - scoreboard bench for press_classifier with timestamp-based reference model
module tb_press_classifier;

    localparam int LONG_CNT   = 20;
    localparam int DCLK_CNT   = 10;
    localparam int REPEAT_CNT = 5;
`ifdef PRESS_CLASSIFIER_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_sync_la_i = 1'b0;
    logic one_shot_i = 1'b0;
    logic sw_clean_i = 1'b0;
    logic single_o, double_o, long_o, repeat_o, busy_o;

    always #5 clk = ~clk;

    press_classifier #(
        .LONG_CNT   (LONG_CNT),
        .DCLK_CNT   (DCLK_CNT),
        .REPEAT_CNT (REPEAT_CNT)
    ) dut (
        .clk_50MHz_i   (clk),
        .rst_sync_la_i (rst_sync_la_i),
        .one_shot_i    (one_shot_i),
        .sw_clean_i    (sw_clean_i),
        .single_o      (single_o),
        .double_o      (double_o),
        .long_o        (long_o),
        .repeat_o      (repeat_o),
        .busy_o        (busy_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Expected pulses: kind bit 0 single, 1 double, 2 long, 3 repeat.
    typedef struct { int cyc; logic [3:0] kind; } pulse_t;
    typedef struct { int cyc; logic val; } busy_t;
    pulse_t pulse_q[$];
    busy_t  busy_q[$];

    // Reference model: a mode plus the cycle it was entered; durations are differences of cycle numbers.
    typedef enum { M_IDLE, M_PRESS, M_GAP, M_PRESS2, M_HOLD } mode_e;
    mode_e m_mode  = M_IDLE;
    int    m_enter = 0;

    function automatic void model_step(input logic os, input logic sw, input logic rst);
        int         n, el;
        mode_e      nxt;
        logic [3:0] k;
        n   = cyc + 1;
        el  = cyc - m_enter;
        nxt = m_mode;
        k   = 4'b0;
        if (!rst) begin
            nxt = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE:  if (os) nxt = M_PRESS;
                M_PRESS: begin
                    if (!sw) nxt = M_GAP;
                    else if (el >= LONG_CNT - 1) begin nxt = M_HOLD; k = 4'b0100; end
                end
                M_GAP: begin
                    if (os) begin nxt = M_PRESS2; k = 4'b0010; end
                    else if (el >= DCLK_CNT - 1) begin nxt = M_IDLE; k = 4'b0001; end
                end
                M_PRESS2: if (!sw) nxt = M_IDLE;
                M_HOLD: begin
                    if (!sw) nxt = M_IDLE;
                    else if (REP_ON && (el % REPEAT_CNT == REPEAT_CNT - 1)) k = 4'b1000;
                end
                default: nxt = M_IDLE;
            endcase
        end
        if (!rst || nxt != m_mode) begin
            m_mode  = nxt;
            m_enter = n;
        end
        busy_q.push_back('{n, nxt != M_IDLE});
        if (k != 4'b0) pulse_q.push_back('{n, k});
    endfunction

    task automatic drive(input logic os, input logic sw, input logic rst);
        one_shot_i    = os;
        sw_clean_i    = sw;
        rst_sync_la_i = rst;
        model_step(os, sw, rst);
        @(posedge clk);
        #1;
    endtask

    // One press cycle with one_shot, then `held` more cycles with the switch down.
    task automatic press(input int held, input bit glitch);
        drive(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < held; i++)
            drive(glitch && ($urandom_range(0, 5) == 0), 1'b1, 1'b1);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: pops whatever the model predicted for this cycle and compares.
    always @(negedge clk) begin
        busy_t      b;
        pulse_t     p;
        logic [3:0] exp_k;
        logic [3:0] obs;
        if (busy_q.size() != 0 && busy_q[0].cyc == cyc) begin
            b = busy_q.pop_front();
            check("busy", {31'b0, busy_o}, {31'b0, b.val});
            exp_k = 4'b0;
            while (pulse_q.size() != 0 && pulse_q[0].cyc <= cyc) begin
                p = pulse_q.pop_front();
                exp_k |= p.kind;
            end
            obs = {repeat_o, long_o, double_o, single_o};
            check("pulses{rep,long,dbl,single}", {28'b0, obs}, {28'b0, exp_k});
            if (obs != 4'b0)
                check("exclusive", {31'b0, ($countones(obs[2:0]) > 1)}, 32'b0);
        end
    end

    initial begin
        // Reset state
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        quiet(3);
        // Single click
        press(4, 1'b0); quiet(15);
        // Double click
        press(4, 1'b0); quiet(3); press(4, 1'b0); quiet(15);
        // Long press, 30 held cycles
        press(29, 1'b0); quiet(15);
        // Long hold for auto-repeat, 40 held cycles
        press(39, 1'b0); quiet(15);
        // Release on the long-timeout cycle
        press(19, 1'b0); quiet(15);
        // One cycle earlier and later around the long boundary
        press(18, 1'b0); quiet(15);
        press(20, 1'b0); quiet(15);
        // Second press on the double-click timeout cycle
        press(4, 1'b0); quiet(10); press(4, 1'b0); quiet(15);
        // Second press one cycle too late
        press(4, 1'b0); quiet(11); press(4, 1'b0); quiet(15);
        // Reset during WAIT2
        press(4, 1'b0); quiet(4); drive(1'b0, 1'b0, 1'b0); quiet(20);
        // Stray one_shot during holds
        press(8, 1'b1); quiet(15);
        press(30, 1'b1); quiet(15);
        // Randomized presses
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 15) == 0) drive(1'b0, $urandom_range(0, 1), 1'b0);
            press($urandom_range(0, 32), 1'b1);
            quiet($urandom_range(1, 14));
        end
        quiet(25);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", pulse_q.size() + busy_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
